// File: rtl/mem_i_d_arbiter_if.sv
// mem_i_d_arbiter_if
//   Requester-side bundle for the unified instruction/data BRAM arbiter.
//   Three ports share one memory:
//     d_* : CPU data port (load/store)
//     i_* : CPU instruction-fetch port (read-only)
//     v_* : video/IO polling port (read-only)
//   Each port has:
//     x_req   : level request, held until x_ack
//     x_addr  : word address
//     x_ack   : combinational accept in the grant cycle
//     x_rdy   : one-cycle completion pulse in the cycle after x_ack
//     x_rdata : read data, valid while x_rdy is high after a read
//   The data port additionally carries d_we and d_wdata.
//   modport master : requester view
//   modport slave  : arbiter view
interface mem_i_d_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_rdy;
  logic [DATA_W-1:0] d_rdata;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic              i_rdy;
  logic [DATA_W-1:0] i_rdata;

  logic              v_req;
  logic [ADDR_W-1:0] v_addr;
  logic              v_ack;
  logic              v_rdy;
  logic [DATA_W-1:0] v_rdata;

  modport master (
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdy, d_rdata,
    output i_req, i_addr,
    input  i_ack, i_rdy, i_rdata,
    output v_req, v_addr,
    input  v_ack, v_rdy, v_rdata
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdy, d_rdata,
    input  i_req, i_addr,
    output i_ack, i_rdy, i_rdata,
    input  v_req, v_addr,
    output v_ack, v_rdy, v_rdata
  );
endinterface

// File: rtl/mem_i_d_arbiter.sv
// mem_i_d_arbiter
//   Shares a single-port 8Kx32 BRAM (one-cycle registered read) between the
//   CPU data port, the CPU fetch port and a read-only video/IO port. At most
//   one access is issued per cycle; the grant is acked combinationally and the
//   matching rdy pulses in the following cycle. Data beats fetch, fetch beats
//   video, except that video jumps to the top once it has lost STARVE_MAX
//   consecutive cycles.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : requester bundle (mem_i_d_arbiter_if.slave)
//   mem_we   : BRAM write enable
//   mem_addr : BRAM address (zero when nothing is granted)
//   mem_din  : BRAM write data (always the data port's write data)
//   mem_dout : BRAM read data, passed straight to every x_rdata
module mem_i_d_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_i_d_arbiter_if.slave  bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  // Tag of the access issued last cycle; decides which rdy pulses now.
  typedef enum logic [2:0] {
    TAG_IDLE = 3'd0,
    TAG_D_RD = 3'd1,
    TAG_D_WR = 3'd2,
    TAG_I_RD = 3'd3,
    TAG_V_RD = 3'd4
  } tag_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_D    = 2'd1,
    GNT_I    = 2'd2,
    GNT_V    = 2'd3
  } gnt_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  tag_e       tag_q;
  tag_e       tag_d;
  logic [7:0] starve_cnt_q;
  logic [7:0] starve_cnt_d;
  gnt_e       gnt_s;
  logic       v_urgent_s;

  // Grant selection: a starved video port pre-empts the fixed priority order.
  // While rst is high nothing is granted, so acks and mem_we stay low.
  always_comb begin
    gnt_s      = GNT_NONE;
    v_urgent_s = bus.v_req && (starve_cnt_q == STARVE_LIM);
    if (rst) begin
      gnt_s = GNT_NONE;
    end else if (v_urgent_s) begin
      gnt_s = GNT_V;
    end else if (bus.d_req) begin
      gnt_s = GNT_D;
    end else if (bus.i_req) begin
      gnt_s = GNT_I;
    end else if (bus.v_req) begin
      gnt_s = GNT_V;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Acks and memory drive for the granted port.
  always_comb begin
    bus.d_ack = 1'b0;
    bus.i_ack = 1'b0;
    bus.v_ack = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    case (gnt_s)
      GNT_D: begin
        bus.d_ack = 1'b1;
        mem_we    = bus.d_we;
        mem_addr  = bus.d_addr;
      end
      GNT_I: begin
        bus.i_ack = 1'b1;
        mem_addr  = bus.i_addr;
      end
      GNT_V: begin
        bus.v_ack = 1'b1;
        mem_addr  = bus.v_addr;
      end
      default: begin
        mem_we   = 1'b0;
        mem_addr = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign mem_din = bus.d_wdata;

  // Next tag and starvation count derived from this cycle's grant.
  always_comb begin
    tag_d        = TAG_IDLE;
    starve_cnt_d = starve_cnt_q;
    case (gnt_s)
      GNT_D:   tag_d = bus.d_we ? TAG_D_WR : TAG_D_RD;
      GNT_I:   tag_d = TAG_I_RD;
      GNT_V:   tag_d = TAG_V_RD;
      default: tag_d = TAG_IDLE;
    endcase
    if (!bus.v_req || (gnt_s == GNT_V)) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q >= STARVE_LIM) begin
      starve_cnt_d = STARVE_LIM;
    end else begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  // State registers; the async clear drops any in-flight completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q        <= TAG_IDLE;
      starve_cnt_q <= 8'd0;
    end else begin
      tag_q        <= tag_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Completion decode: rdy comes straight off the tag register, and read data
  // is the BRAM's registered output passed through to every port.
  always_comb begin
    bus.d_rdy   = (tag_q == TAG_D_RD) || (tag_q == TAG_D_WR);
    bus.i_rdy   = (tag_q == TAG_I_RD);
    bus.v_rdy   = (tag_q == TAG_V_RD);
    bus.d_rdata = mem_dout;
    bus.i_rdata = mem_dout;
    bus.v_rdata = mem_dout;
  end

endmodule

// File: tb/tb_mem_i_d_arbiter.sv
// tb_mem_i_d_arbiter
//   Drives the arbiter next to a behavioural single-port BRAM. Each scenario
//   task pushes expected completions into a scoreboard queue when it presents
//   a request and pops/compares them when rdy pulses.
module tb_mem_i_d_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Backdoor preload port into the BRAM model.
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [DATA_W-1:0] bd_data;

  logic [DATA_W-1:0] bram [0:8191];

  mem_i_d_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  mem_i_d_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: write at the edge, registered read, D_Out held on writes.
  always @(posedge clk) begin
    if (bd_we) bram[bd_addr] <= bd_data;
    else if (mem_we) bram[mem_addr] <= mem_din;
    else mem_dout <= bram[mem_addr];
  end

  typedef struct {
    logic [2:0]  port;   // {d,i,v} rdy pattern expected
    logic        chk;    // compare read data
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] P_D = 3'b100;
  localparam logic [2:0] P_I = 3'b010;
  localparam logic [2:0] P_V = 3'b001;

  // Preload table.
  logic [12:0] pl_addr [8] = '{13'h0005, 13'h0010, 13'h0004, 13'h0020,
                              13'h0000, 13'h0001, 13'h0002, 13'h1000};
  logic [31:0] pl_data [8] = '{32'h1111_0005, 32'h8C01_0004, 32'h4444_0004, 32'h2222_0020,
                              32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'h0000_0000};

  function automatic logic [2:0] rdy_vec();
    return {bus_if.d_rdy, bus_if.i_rdy, bus_if.v_rdy};
  endfunction

  function automatic logic [31:0] rdata_of(input logic [2:0] p);
    case (p)
      P_D:     return bus_if.d_rdata;
      P_I:     return bus_if.i_rdata;
      default: return bus_if.v_rdata;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus_if.d_req = 1'b0; bus_if.i_req = 1'b0; bus_if.v_req = 1'b0;
    bus_if.d_we = 1'b0;
  endtask

  task automatic preload();
    for (int k = 0; k < 8; k++) begin
      bd_we = 1'b1; bd_addr = pl_addr[k]; bd_data = pl_data[k];
      tick();
    end
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b0; bus_if.d_addr = 13'h0005;
    bus_if.i_req = 1'b1; bus_if.i_addr = 13'h0010;
    bus_if.v_req = 1'b1; bus_if.v_addr = 13'h0020;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.d_ack, bus_if.i_ack, bus_if.v_ack, rdy_vec(), mem_we} !== 7'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b required 0000000",
                        {bus_if.d_ack, bus_if.i_ack, bus_if.v_ack, rdy_vec(), mem_we});
    end
    n_cmp++;
    if (mem_addr !== 13'h0000) begin
      n_bad++; $display("FAIL reset_addr: got %h required 0000", mem_addr);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.d_ack, bus_if.i_ack, bus_if.v_ack} !== 3'b100 || mem_addr !== 13'h0005) begin
      n_bad++; $display("FAIL release_ack: acks=%b addr=%h required 100 addr 0005",
                        {bus_if.d_ack, bus_if.i_ack, bus_if.v_ack}, mem_addr);
    end
    sb.push_back('{P_D, 1'b1, 32'h1111_0005});
    tick();
    idle_reqs();
    @(negedge clk);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL release_sb: queue empty, rdy=%b", rdy_vec());
    end else begin
      e = sb.pop_front();
      if (rdy_vec() !== e.port || rdata_of(e.port) !== e.data) begin
        n_bad++; $display("FAIL release_rdy: rdy=%b data=%h required %b %h",
                          rdy_vec(), rdata_of(e.port), e.port, e.data);
      end
    end
  endtask

  task automatic test_single_fetch();
    exp_t e;
    tick();
    bus_if.i_req = 1'b1; bus_if.i_addr = 13'h0010;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.d_ack, bus_if.i_ack, bus_if.v_ack} !== 3'b010) begin
      n_bad++; $display("FAIL fetch_ack: got %b required 010", {bus_if.d_ack, bus_if.i_ack, bus_if.v_ack});
    end
    sb.push_back('{P_I, 1'b1, 32'h8C01_0004});
    tick();
    idle_reqs();
    @(negedge clk);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL fetch_sb: queue empty, rdy=%b", rdy_vec());
    end else begin
      e = sb.pop_front();
      if (rdy_vec() !== e.port || rdata_of(e.port) !== e.data) begin
        n_bad++; $display("FAIL fetch_rdy: rdy=%b data=%h required %b %h",
                          rdy_vec(), rdata_of(e.port), e.port, e.data);
      end
    end
  endtask

  task automatic test_contention();
    exp_t e;
    tick();
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b1; bus_if.d_addr = 13'h1000; bus_if.d_wdata = 32'hDEAD_BEEF;
    bus_if.i_req = 1'b1; bus_if.i_addr = 13'h0004;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.d_ack, bus_if.i_ack, mem_we} !== 3'b101 || mem_addr !== 13'h1000) begin
      n_bad++; $display("FAIL contend_c0: d_ack,i_ack,we=%b addr=%h required 101 1000",
                        {bus_if.d_ack, bus_if.i_ack, mem_we}, mem_addr);
    end
    sb.push_back('{P_D, 1'b0, 32'h0});
    // The write completes; the fetch loser is still waiting and now wins.
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) begin bus_if.d_req = 1'b0; bus_if.d_we = 1'b0; end
      if (c == 2) begin
        bus_if.i_req = 1'b0;
        bus_if.d_req = 1'b1; bus_if.d_we = 1'b0; bus_if.d_addr = 13'h1000;
      end
      if (c == 3) idle_reqs();
      @(negedge clk);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++; $display("FAIL contend_sb: cycle %0d queue empty, rdy=%b", c, rdy_vec());
      end else begin
        e = sb.pop_front();
        if (rdy_vec() !== e.port || (e.chk && rdata_of(e.port) !== e.data)) begin
          n_bad++; $display("FAIL contend_rdy: cycle %0d rdy=%b data=%h required %b %h",
                            c, rdy_vec(), rdata_of(e.port), e.port, e.data);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if ({bus_if.d_ack, bus_if.i_ack} !== 2'b01) begin
          n_bad++; $display("FAIL contend_c1_ack: got %b required 01", {bus_if.d_ack, bus_if.i_ack});
        end
        sb.push_back('{P_I, 1'b1, 32'h4444_0004});
      end
      if (c == 2) begin
        n_cmp++;
        if ({bus_if.d_ack, mem_we} !== 2'b10) begin
          n_bad++; $display("FAIL contend_rd_ack: d_ack,we=%b required 10", {bus_if.d_ack, mem_we});
        end
        sb.push_back('{P_D, 1'b1, 32'hDEAD_BEEF});
      end
    end
  endtask

  task automatic test_starvation();
    exp_t e;
    logic exp_v;
    tick();
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b0; bus_if.d_addr = 13'h0005;
    bus_if.v_req = 1'b1; bus_if.v_addr = 13'h0020;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) tick();
      if (c == 10) idle_reqs();
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL starve_sb: cycle %0d queue empty, rdy=%b", c, rdy_vec());
        end else begin
          e = sb.pop_front();
          if (rdy_vec() !== e.port || rdata_of(e.port) !== e.data) begin
            n_bad++; $display("FAIL starve_rdy: cycle %0d rdy=%b data=%h required %b %h",
                              c, rdy_vec(), rdata_of(e.port), e.port, e.data);
          end
        end
      end
      if (c < 10) begin
        exp_v = (c == 8);
        n_cmp++;
        if ({bus_if.d_ack, bus_if.v_ack} !== {~exp_v, exp_v}) begin
          n_bad++; $display("FAIL starve_ack: cycle %0d d_ack,v_ack=%b required %b",
                            c, {bus_if.d_ack, bus_if.v_ack}, {~exp_v, exp_v});
        end
        if (exp_v) sb.push_back('{P_V, 1'b1, 32'h2222_0020});
        else       sb.push_back('{P_D, 1'b1, 32'h1111_0005});
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c <= 3; c++) begin
      tick();
      if (c < 3) begin bus_if.i_req = 1'b1; bus_if.i_addr = 13'(c); end
      else idle_reqs();
      @(negedge clk);
      if (c < 3) begin
        n_cmp++;
        if (bus_if.i_ack !== 1'b1 || mem_addr !== 13'(c)) begin
          n_bad++; $display("FAIL b2b_ack: cycle %0d i_ack=%b addr=%h required 1 %h",
                            c, bus_if.i_ack, mem_addr, 13'(c));
        end
        sb.push_back('{P_I, 1'b1, 32'hA000_0000 + 32'(c)});
      end
      if (c > 0) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL b2b_sb: cycle %0d queue empty, rdy=%b", c, rdy_vec());
        end else begin
          e = sb.pop_front();
          if (rdy_vec() !== e.port || rdata_of(e.port) !== e.data) begin
            n_bad++; $display("FAIL b2b_rdy: cycle %0d rdy=%b data=%h required %b %h",
                              c, rdy_vec(), rdata_of(e.port), e.port, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    tick();
    bus_if.i_req = 1'b1; bus_if.i_addr = 13'h0010;
    @(negedge clk);
    n_cmp++;
    if (bus_if.i_ack !== 1'b1) begin
      n_bad++; $display("FAIL midop_ack: i_ack=%b required 1", bus_if.i_ack);
    end
    #1 rst = 1'b1;   // async, before the next edge; the access is dropped
    tick();
    @(negedge clk);
    n_cmp++;
    if ({rdy_vec(), bus_if.i_ack, mem_we} !== 5'b0) begin
      n_bad++; $display("FAIL midop_flush: rdy,i_ack,we=%b required 00000",
                        {rdy_vec(), bus_if.i_ack, mem_we});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_if.i_ack !== 1'b1) begin
      n_bad++; $display("FAIL midop_reissue_ack: i_ack=%b required 1", bus_if.i_ack);
    end
    sb.push_back('{P_I, 1'b1, 32'h8C01_0004});
    tick();
    idle_reqs();
    @(negedge clk);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL midop_sb: queue empty, rdy=%b", rdy_vec());
    end else begin
      e = sb.pop_front();
      if (rdy_vec() !== e.port || rdata_of(e.port) !== e.data) begin
        n_bad++; $display("FAIL midop_rdy: rdy=%b data=%h required %b %h",
                          rdy_vec(), rdata_of(e.port), e.port, e.data);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bd_we = 1'b0; bd_addr = 13'h0; bd_data = 32'h0;
    idle_reqs();
    bus_if.d_addr = 13'h0; bus_if.d_wdata = 32'h0;
    bus_if.i_addr = 13'h0; bus_if.v_addr = 13'h0;
    preload();
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_back_to_back();
    test_reset_midop();
    tick();
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0 || rdy_vec() !== 3'b000) begin
      n_bad++; $display("FAIL drain: %0d entries left, rdy=%b required 0 000", sb.size(), rdy_vec());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
